// File: rtl/imem_fetch.sv
// imem_fetch -- instruction-fetch initiator (master side of harvos_imem_if).
//
// Walks a word-aligned PC, issues one fetch request per cycle while credit
// allows, and queues returned words in a FIFO_DEPTH-entry prefetch FIFO
// toward decode. The FIFO count plus the outstanding requests never exceed
// FIFO_DEPTH, so every response always has a slot waiting for it. A redirect
// flushes the FIFO and discards in-flight responses. A fault response is
// delivered as a single entry, and fetch then stops until the next redirect.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req/addr     fetch request and word address (slave samples at posedge)
//   imem_rvalid/rdata/fault
//                     in-order response, latency >= 1, fault qualified by rvalid
//   redirect_valid/pc flush and restart at redirect_pc (low two bits ignored)
//   inst_valid/ready  head-of-FIFO handshake toward decode
//   inst_data/pc/fault
//                     head entry; data reads 0 for a fault entry, and all
//                     three read 0 while the FIFO is empty
module imem_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  // Entry layout: {data[64:33], pc[32:1], fault[0]}
  logic [64:0]   fifo_mem_q [FIFO_DEPTH];
  logic [64:0]   push_entry;
  logic [64:0]   head;

  logic [31:0]   redirect_aligned;
  logic          credit_ok;
  logic          push;
  logic          pop;
  logic          unused_redirect_lsb;

  assign redirect_aligned    = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Same-cycle pop deliberately does not free credit: keeps req off the
  // FIFO read path.
  assign credit_ok = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CW+1)'(FIFO_DEPTH);

  // A response is kept only when nothing older is still being discarded,
  // no redirect is flushing this cycle, and fetch is not halted.
  assign push = imem_rvalid && (discard_q == '0) && !redirect_valid && (state_q == RUN);
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  assign push_entry = {(imem_fault ? 32'd0 : imem_rdata), resp_pc_q, imem_fault};
  assign head       = fifo_mem_q[rd_ptr_q];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // FSM next state: a redirect always restarts fetch; a kept fault halts it
  always_comb begin
    state_d = state_q;
    if (redirect_valid)          state_d = RUN;
    else if (push && imem_fault) state_d = HALT;
  end

  // FSM / head outputs; req is forced low while reset is held
  always_comb begin
    imem_req   = rst_n && (state_q == RUN) && !redirect_valid && credit_ok;
    imem_addr  = pc_q;
    inst_valid = (count_q != '0);
    inst_data  = inst_valid ? head[64:33] : 32'd0;
    inst_pc    = inst_valid ? head[32:1]  : 32'd0;
    inst_fault = inst_valid && head[0];
  end

  // Datapath next-state: PCs, credit counters, FIFO pointers
  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CW'(imem_req) - CW'(imem_rvalid);
    discard_d     = discard_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (imem_req) pc_d = pc_q + 32'd4;

    if (redirect_valid) begin
      // No req in this cycle, so everything still in flight after this
      // cycle's response (if any, itself dropped) must be thrown away.
      pc_d      = redirect_aligned;
      resp_pc_d = redirect_aligned;
      discard_d = outstanding_q - CW'(imem_rvalid);
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else begin
      if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - 1'b1;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        // Everything requested behind the faulting word is now stale.
        if (imem_fault) discard_d = outstanding_d;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control/pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // FIFO storage: data only, validity lives in count_q
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
  end

`ifndef SYNTHESIS
  // The credit rule guarantees a free slot for every response.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_q == CW'(FIFO_DEPTH))));
`endif

endmodule
